core_boot_loader: RTL

//  Synthesizable boot sequencer that sits directly upstream of core_flattened and data_mem.

---
 rtl/core_boot_loader.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/core_boot_loader.sv
// Boot sequencer: copies the data ROM image into data memory, then streams INSTR, REG, BAR, PC
// and NULL packets to the core. Define BOOT_CHECKSUM_EN to enable the running checksum_o.
package core_boot_loader_pkg;
  typedef enum logic [2:0] {
    NET_NULL  = 3'd0,
    NET_INSTR = 3'd1,
    NET_REG   = 3'd2,
    NET_PC    = 3'd3,
    NET_BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  id;
    net_op_e     net_op;
    logic [4:0]  reserved;
    logic [31:0] net_data;
    logic [9:0]  net_addr;
  } net_packet_s;
endpackage

module core_boot_loader
  import core_boot_loader_pkg::*;
#(
  parameter int unsigned INSTR_WORDS = 1024,
  parameter int unsigned DATA_WORDS  = 1024,
  parameter int unsigned REG_WORDS   = 64,
  parameter logic [9:0]  CORE_ID     = 10'd1,
  parameter logic [31:0] BAR_MASK    = 32'h2,
  parameter logic [31:0] START_PC    = 32'h5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic [9:0]  irom_addr_o,
  input  logic [15:0] irom_data_i,
  output logic [9:0]  drom_addr_o,
  input  logic [31:0] drom_data_i,
  output logic [5:0]  rrom_addr_o,
  input  logic [39:0] rrom_data_i,
  output logic        dmem_valid_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output net_packet_s pkt_o,
  output logic        pkt_valid_o,
  input  logic        pkt_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] checksum_o
);

  localparam logic [9:0] INSTR_LAST = 10'(INSTR_WORDS - 1);
  localparam logic [9:0] DATA_LAST  = 10'(DATA_WORDS - 1);
  localparam logic [9:0] REG_LAST   = 10'(REG_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DMEM, S_INSTR, S_REG, S_BAR, S_PC, S_NULLP, S_DONE
  } state_e;

  // FETCH: ROM address presented; SEND: ROM data valid; HOLD: packet waiting for accept
  typedef enum logic [1:0] {PH_FETCH, PH_SEND, PH_HOLD} phase_e;

  state_e     state_q;
  phase_e     phase_q;
  logic [9:0] idx_q;
  logic [9:0] idx_nxt_c;
  logic       unused_rrom_c;

  assign idx_nxt_c     = idx_q + 10'd1;
  assign unused_rrom_c = ^rrom_data_i[39:38];

  function automatic net_packet_s mk_pkt(input net_op_e op, input logic [31:0] data,
                                         input logic [9:0] addr);
    net_packet_s p;
    p.id       = CORE_ID;
    p.net_op   = op;
    p.reserved = '0;
    p.net_data = data;
    p.net_addr = addr;
    return p;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_FETCH;
      idx_q        <= '0;
      irom_addr_o  <= '0;
      drom_addr_o  <= '0;
      rrom_addr_o  <= '0;
      dmem_valid_o <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      pkt_o        <= '0;
      pkt_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      dmem_valid_o <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q     <= S_DMEM;
            phase_q     <= PH_FETCH;
            idx_q       <= '0;
            drom_addr_o <= '0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
          end
        end
        S_DMEM: begin
          if (phase_q == PH_FETCH) begin
            phase_q <= PH_SEND;
          end else begin
            dmem_valid_o <= 1'b1;
            dmem_addr_o  <= 32'(idx_q) << 2;
            dmem_wdata_o <= drom_data_i;
            phase_q      <= PH_FETCH;
            if (idx_q == DATA_LAST) begin
              state_q     <= S_INSTR;
              idx_q       <= '0;
              irom_addr_o <= '0;
            end else begin
              idx_q       <= idx_nxt_c;
              drom_addr_o <= idx_nxt_c;
            end
          end
        end
        S_INSTR: begin
          if (phase_q == PH_FETCH) begin
            phase_q <= PH_SEND;
          end else if (phase_q == PH_SEND) begin
            pkt_o       <= mk_pkt(NET_INSTR, {16'h0, irom_data_i}, idx_q);
            pkt_valid_o <= 1'b1;
            phase_q     <= PH_HOLD;
          end else if (pkt_ready_i) begin
            pkt_valid_o <= 1'b0;
            phase_q     <= PH_FETCH;
            if (idx_q == INSTR_LAST) begin
              state_q     <= S_REG;
              idx_q       <= '0;
              rrom_addr_o <= '0;
            end else begin
              idx_q       <= idx_nxt_c;
              irom_addr_o <= idx_nxt_c;
            end
          end
        end
        S_REG: begin
          if (phase_q == PH_FETCH) begin
            phase_q <= PH_SEND;
          end else if (phase_q == PH_SEND) begin
            pkt_o       <= mk_pkt(NET_REG, rrom_data_i[31:0], {4'h0, rrom_data_i[37:32]});
            pkt_valid_o <= 1'b1;
            phase_q     <= PH_HOLD;
          end else if (pkt_ready_i) begin
            phase_q <= PH_FETCH;
            if (idx_q == REG_LAST) begin
              state_q <= S_BAR;
              idx_q   <= '0;
              pkt_o   <= mk_pkt(NET_BAR, BAR_MASK, 10'd24);
            end else begin
              pkt_valid_o <= 1'b0;
              idx_q       <= idx_nxt_c;
              rrom_addr_o <= 6'(idx_nxt_c);
            end
          end
        end
        // Fixed packets: the next one is loaded on the edge the current one is accepted
        S_BAR: begin
          if (pkt_ready_i) begin
            state_q <= S_PC;
            pkt_o   <= mk_pkt(NET_PC, START_PC, 10'd0);
          end
        end
        S_PC: begin
          if (pkt_ready_i) begin
            state_q <= S_NULLP;
            pkt_o   <= mk_pkt(NET_NULL, 32'hFFFF_FFFE, 10'd24);
          end
        end
        S_NULLP: begin
          if (pkt_ready_i) begin
            state_q     <= S_DONE;
            pkt_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] csum_q;
  logic [31:0] csum_add_c;

  // Each word is added once, in the single SEND cycle where it is issued
  always_comb begin
    csum_add_c = '0;
    if (phase_q == PH_SEND) begin
      case (state_q)
        S_DMEM:  csum_add_c = drom_data_i;
        S_INSTR: csum_add_c = {16'h0, irom_data_i};
        S_REG:   csum_add_c = rrom_data_i[31:0];
        default: csum_add_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (start_i && (state_q == S_IDLE || state_q == S_DONE)) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_q + csum_add_c;
    end
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

endmodule
